ifetch_queue: RTL

//  Instruction fetch front-end feeding the datapath: owns the fetch PC, issues
//  in-order word reads to instruction memory over a valid/ready request port,

---
 rtl/ifetch_queue_pkg.sv | 27 ++
 rtl/ifetch_queue_fifo.sv | 71 +++++++
 rtl/ifetch_queue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_queue_pkg
// Purpose : Shared definitions for the instruction fetch front-end: widths,
//           PC increment, default reset PC and the queue entry layout.
// Rev     : 1.0  initial release
// ============================================================================
package ifetch_queue_pkg;

    localparam int          XLEN             = 32;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // One queued instruction together with the byte address it came from
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are discarded
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Purpose : Synchronous FIFO of {pc,instr} entries with push/pop/flush.
//           Head output reads zero while empty so downstream sees clean data.
// Rev     : 1.0  initial release
// ============================================================================
module fetch_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,      // asynchronous, active-low
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_eff;
    logic            pop_eff;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign pop_eff  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves the same cycle
    assign push_eff = push && (!full || pop_eff);
    assign head     = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over any push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + AW'(1);
            if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until pointed at by a valid count
    always_ff @(posedge clk) begin
        if (push_eff && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_queue
// Purpose : Instruction fetch front-end. Issues in-order word reads under a
//           credit limit, queues returned words with their PC, and discards
//           responses belonging to fetches made before a redirect.
// Rev     : 1.0  initial release
// ============================================================================
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,            // asynchronous, active-low
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;      // address of the next response that will be kept
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic          running;      // keeps requests off until the first clock after reset

    logic          req_fire;
    logic          resp_fire;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;

    // Queued entries and outstanding reads share the same DEPTH credits,
    // so every response is guaranteed a free slot on arrival.
    assign credit_ok      = ({1'b0, fifo_count} + {1'b0, inflight}) < CREDIT_LIMIT;
    assign imem_req_valid = running && credit_ok && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is ignored entirely
    assign resp_fire  = imem_resp_valid && (inflight != '0);
    assign resp_drop  = resp_fire && (drop != '0);
    assign push       = resp_fire && (drop == '0) && !redirect_valid;
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign push_entry = '{pc: resp_pc, instr: imem_resp_data};

    assign out_valid = !fifo_empty;
    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fetch address: redirect target takes priority, else advance per accepted request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= align_pc(RESET_PC);
            running  <= 1'b0;
        end else begin
            running <= 1'b1;
            if (redirect_valid)
                fetch_pc <= align_pc(redirect_pc);
            else if (req_fire)
                fetch_pc <= fetch_pc + PC_INC;
        end
    end

    // Outstanding reads; no request can fire during a redirect cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({req_fire, resp_fire})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Discard counter: on redirect every read still outstanding after this
    // cycle predates the redirect, so all of them must be thrown away.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop <= '0;
        end else if (redirect_valid) begin
            drop <= inflight - CW'(resp_fire);
        end else if (resp_drop) begin
            drop <= drop - CW'(1);
        end
    end

    // PC tag for kept responses; after a redirect the next kept one is the target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_pc <= align_pc(RESET_PC);
        end else if (redirect_valid) begin
            resp_pc <= align_pc(redirect_pc);
        end else if (push) begin
            resp_pc <= resp_pc + PC_INC;
        end
    end

    a_resp_has_request: assert property (
        @(posedge clk) disable iff (!reset) imem_resp_valid |-> (inflight != '0));

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset) push |-> (!fifo_full || pop));

endmodule
`default_nettype wire
